// File: rtl/uart_cmd_seq.sv
// Command FIFO feeding a UART-style serialiser (start, DATA_W bits LSB first, STOP_BITS, optional idle gap).
// Latency: a push into an empty idle block drives the start bit 3 clocks later; frames run back-to-back from the FIFO.
// Backpressure: full is registered, so pushes while full are dropped and set sticky ovfl. Optional parity bit: define UART_CMD_SEQ_PARITY_EN.
module uart_cmd_seq #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int BAUD_DIV  = 2604,
    parameter int STOP_BITS = 1,
    parameter int GAP_CYC   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
`ifdef UART_CMD_SEQ_PARITY_EN
    input  logic                     par_odd,
`endif
    output logic                     TX,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     ovfl
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_W + 1);

    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [15:0]   GAP_LOAD  = (GAP_CYC > 0) ? 16'(GAP_CYC - 1) : 16'd0;

`ifdef UART_CMD_SEQ_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PAR, STOP, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, GAP} state_t;
`endif

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   shreg;
    logic [BW-1:0]       baud_cnt;
    logic [IW-1:0]       bit_idx;
    logic                stop_idx;
    logic [15:0]         gap_cnt;
`ifdef UART_CMD_SEQ_PARITY_EN
    logic                par_bit;
`endif

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // flush has priority over both ends of the FIFO; the shifter still takes the head in LOAD.
    assign push  = wr_en && !full && !flush;
    assign pop   = (state == LOAD) && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovfl   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovfl   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (wr_en && full) begin
                ovfl <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            TX       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            gap_cnt  <= '0;
`ifdef UART_CMD_SEQ_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    TX <= 1'b1;
                    if (!empty) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    // A flush landing between IDLE and LOAD leaves nothing to send.
                    if (empty) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        shreg    <= mem[rd_ptr];
`ifdef UART_CMD_SEQ_PARITY_EN
                        par_bit  <= (^mem[rd_ptr]) ^ par_odd;
`endif
                        TX       <= 1'b0;
                        baud_cnt <= BAUD_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        TX       <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_CMD_SEQ_PARITY_EN
                            TX       <= par_bit;
                            state    <= PAR;
`else
                            TX       <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= STOP;
`endif
                        end else begin
                            TX      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_CMD_SEQ_PARITY_EN
                PAR: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        TX       <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (stop_idx == LAST_STOP) begin
                            tx_done <= 1'b1;
                            if (GAP_CYC > 0) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            baud_cnt <= BAUD_LOAD;
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    TX    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Bench for uart_cmd_seq: a serial monitor decodes every frame on the main instance and checks it against a queue
// of bytes the bench expects to be sent; a second instance exercises two stop bits and the inter-frame gap.
module tb_uart_cmd_seq;

    localparam int B    = 16;
    localparam int HB   = B / 2;
    localparam int DW   = 8;
    localparam int GAP  = 20;
`ifdef UART_CMD_SEQ_PARITY_EN
    localparam int PB   = 1;
`else
    localparam int PB   = 0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       par_odd_v;
    logic       tx, full, empty, busy, tx_done, ovfl;
    logic [3:0] count;

    logic       g_wr_en;
    logic [7:0] g_wr_data;
    logic       g_flush;
    logic       g_tx, g_full, g_empty, g_busy, g_tx_done, g_ovfl;
    logic [3:0] g_count;

    uart_cmd_seq #(.DATA_W(DW), .DEPTH(8), .BAUD_DIV(B), .STOP_BITS(1), .GAP_CYC(0)) u_main (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
`ifdef UART_CMD_SEQ_PARITY_EN
        .par_odd(par_odd_v),
`endif
        .TX(tx), .full(full), .empty(empty), .count(count), .busy(busy), .tx_done(tx_done), .ovfl(ovfl)
    );

    uart_cmd_seq #(.DATA_W(DW), .DEPTH(8), .BAUD_DIV(B), .STOP_BITS(2), .GAP_CYC(GAP)) u_gap (
        .clk(clk), .rst_n(rst_n), .wr_en(g_wr_en), .wr_data(g_wr_data), .flush(g_flush),
`ifdef UART_CMD_SEQ_PARITY_EN
        .par_odd(par_odd_v),
`endif
        .TX(g_tx), .full(g_full), .empty(g_empty), .count(g_count), .busy(g_busy), .tx_done(g_tx_done), .ovfl(g_ovfl)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    int         extra  = 0;
    int         g_done_cnt = 0;
    logic       rst_seen = 1'b0;
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (tx && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, tx, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || !empty) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {busy, !empty}, 0);
    endtask

    // Samples each bit at its midpoint; a reset anywhere in the frame abandons it.
    task automatic mon_frame();
        logic [7:0] d;
        logic [7:0] e;
        logic       p;
        d = '0;
        p = 1'b0;
        rst_seen = 1'b0;
        repeat (HB) @(posedge clk);
        #1;
        if (rst_seen) return;
        chk("start_bit", tx, 0);
        for (int i = 0; i < DW; i++) begin
            repeat (B) @(posedge clk);
            #1;
            if (rst_seen) return;
            d[i] = tx;
        end
`ifdef UART_CMD_SEQ_PARITY_EN
        repeat (B) @(posedge clk);
        #1;
        if (rst_seen) return;
        p = tx;
`endif
        repeat (B) @(posedge clk);
        #1;
        if (rst_seen) return;
        chk("stop_bit", tx, 1);
        if (sb.size() == 0) begin
            extra++;
        end else begin
            e = sb.pop_front();
            chk("frame_data", d, e);
`ifdef UART_CMD_SEQ_PARITY_EN
            chk("parity_bit", p, (^e) ^ par_odd_v);
`endif
        end
        if (p) d = '0;
    endtask

    initial forever begin
        @(negedge rst_n);
        rst_seen = 1'b1;
    end

    initial forever begin
        @(negedge tx);
        if (rst_n) mon_frame();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (g_tx_done) g_done_cnt++;
    end

    initial begin
        int k;
        int low_cnt;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        flush     = 1'b0;
        par_odd_v = 1'b0;
        g_wr_en   = 1'b0;
        g_wr_data = '0;
        g_flush   = 1'b0;

        repeat (50) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovfl", ovfl, 0);
        chk("rst_tx_done", tx_done, 0);
        rst_n = 1'b1;
        low_cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (!tx) low_cnt++;
        end
        chk("idle_tx_low_cycles", low_cnt, 0);

        // Single 'g': start bit 3 clocks after the push edge, tx_done 160 clocks after the fall.
        sb.push_back(8'h67);
        push(8'h67);
        k = 1;
        while (tx && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("start_latency", k, 3);
        chk("busy_in_frame", busy, 1);
        k = 0;
        while (!tx_done && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("tx_done_delay", k, (1 + DW + PB + 1) * B);
        chk("busy_at_done", busy, 0);
        @(posedge clk); #1;
        chk("tx_done_width", tx_done, 0);
        chk("count_after_g", count, 0);
        chk("empty_after_g", empty, 1);
        repeat (20) @(posedge clk);
        #1;

        // Burst of 10: one pop happens in LOAD during the burst, so 0x01..0x09 fit and 0x0A drops.
        for (int i = 1; i <= 9; i++) sb.push_back(8'(i));
        for (int i = 1; i <= 10; i++) push(8'(i));
        chk("burst_ovfl", ovfl, 1);
        chk("burst_full", full, 1);
        chk("burst_count", count, 8);
        wait_idle("burst_drain", 3000);
        chk("ovfl_sticky", ovfl, 1);
        repeat (20) @(posedge clk);
        #1;

        // Flush during the first frame's data bits: that frame finishes, the rest vanish.
        sb.push_back(8'h67);
        push(8'h67);
        push(8'h73);
        push(8'h3F);
        wait_fall("flush_start");
        repeat (40) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ovfl", ovfl, 0);
        chk("flush_frame_continues", busy, 1);
        wait_idle("flush_drain", 400);
        repeat (200) @(posedge clk);
        #1;
        chk("flush_no_more_frames", busy, 0);

        // Flush and push together: push discarded, no overflow, nothing sent.
        wr_en   = 1'b1;
        wr_data = 8'h55;
        flush   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        flush   = 1'b0;
        chk("flush_push_count", count, 0);
        chk("flush_push_ovfl", ovfl, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("flush_push_busy", busy, 0);

        // Two stop bits plus 20-cycle gap: TX high 2*B+20+2 clocks from end of data to next start.
        g_wr_en   = 1'b1;
        g_wr_data = 8'h67;
        @(posedge clk); #1;
        g_wr_data = 8'h3F;
        @(posedge clk); #1;
        g_wr_en   = 1'b0;
        k = 0;
        while (g_tx && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("gap_first_start", g_tx, 0);
        repeat ((1 + DW + PB) * B) @(posedge clk);
        #1;
        chk("gap_stop_level", g_tx, 1);
        k = 0;
        while (g_tx && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("gap_high_cycles", k, 2 * B + GAP + 2);
        k = 0;
        while ((g_busy || !g_empty) && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("gap_idle", g_busy, 0);
        chk("gap_done_pulses", g_done_cnt, 2);
        chk("gap_count", g_count, 0);
        chk("gap_full", g_full, 0);
        chk("gap_ovfl", g_ovfl, 0);

        // Reset in the middle of data bit 4 of 0x67 (a 0 bit): TX must go high at once.
        push(8'h67);
        wait_fall("rst_mid_start");
        repeat (5 * B + HB) @(posedge clk);
        #1;
        chk("pre_reset_bit4", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_tx_high", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", count, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        par_odd_v = 1'b0;
        sb.push_back(8'h67);
        push(8'h67);
        wait_fall("post_reset_start");
        wait_idle("post_reset_drain", 400);

        repeat (50) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("unexpected_frames", extra, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_seq.md
Name: uart_cmd_seq

Overview:
Parametrised command sequencer that replaces the single-shot UART transmitter used to issue rider commands, for example 'g' to the Segway RX pin.
- Commands are written into an internal FIFO.
- Each command is serialised as an 8N1-style UART frame with configurable data width, stop bits, baud divisor and inter-frame gap.
- Scripted command sequences therefore run without the driver polling tx_done per byte.
- Synthesizable: usable as a bench stimulus driver and as an on-board BLE stand-in.

Parameters:
- DATA_W, 8: bits per character, 5..9.
- DEPTH, 8: FIFO entries; power of 2, 2..64.
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200); must be >= 4.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- GAP_CYC, 0: idle-high clocks inserted after each frame's final stop bit, 0..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  DATA_W  command character.
- flush  in  1  synchronous FIFO clear.
- TX  out  1  serial output; idle high.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  frame or gap in progress.
- tx_done  out  1  one-cycle pulse per completed frame.
- ovfl  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async, rst_n low):
  - TX=1, busy=0, tx_done=0, ovfl=0, count=0, empty=1, full=0.
  - State=IDLE, FIFO pointers=0.
  - Reset mid-frame forces TX high immediately, with no partial-frame completion.
- FIFO:
  - Push accepted when wr_en && !full. full is the registered value, so a push while full is dropped even if a pop occurs the same cycle; that drop sets ovfl.
  - Pushed data is visible to the transmitter the cycle after the push.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Flush:
  - Clears pointers and count and clears ovfl.
  - Does not abort a frame already loaded into the shifter; that frame completes normally.
  - Flush and wr_en in the same cycle: flush wins and the push is discarded (no ovfl).
- FSM states: IDLE, LOAD, START, DATA, PAR (optional feature only), STOP, GAP.
  - IDLE: if !empty, go to LOAD.
  - LOAD: pop the FIFO head into the shift register, set busy=1, go to START.
  - START: TX=0 for BAUD_DIV clocks.
  - DATA: DATA_W bits, LSB first, each BAUD_DIV clocks.
  - STOP: TX=1 for STOP_BITS*BAUD_DIV clocks.
  - tx_done pulses on the final clock of STOP.
  - From STOP: go to GAP if GAP_CYC>0, else IDLE.
  - GAP: TX=1 for GAP_CYC clocks, then IDLE.
  - busy is 1 in LOAD..GAP and 0 in IDLE.
- Latency: wr_en into an empty, idle block gives TX falling edge 3 clocks later (push, IDLE detect, LOAD).
- Back-to-back frames with GAP_CYC=0: 2 idle-high clocks (IDLE, LOAD) between a stop bit and the next start bit.
- Counters:
  - Baud counter counts down from BAUD_DIV-1 and reloads on each bit boundary.
  - Bit index width is $clog2(DATA_W+1).
  - Gap counter is 16 bits.
- TX is registered, with no glitches on state changes.

Optional Feature:
Macro UART_CMD_SEQ_PARITY_EN.
- Defined: adds input par_odd (1 bit).
- PAR state follows DATA and lasts BAUD_DIV clocks.
- PAR drives the XOR of the data bits when par_odd=0 (even parity), or its inverse when par_odd=1.
- Frame length grows by one bit.
- Not defined: no par_odd port and no PAR state; DATA goes directly to STOP.

Test Plan:
- Reset: hold rst_n low 50 clocks -> TX=1, empty=1, count=0, busy=0, ovfl=0. Release, then idle 100 clocks -> TX stays 1.
- Single 'g', with BAUD_DIV=16, DATA_W=8, STOP_BITS=1: push 8'h67 -> TX low 3 clocks after the push. Bits sampled at mid-bit read 0,1,1,1,0,0,1,1,0,1. tx_done pulses exactly 160 clocks after TX falls. count returns to 0.
- Burst/overflow, DEPTH=8: push 10 bytes 8'h01..8'h0A on consecutive clocks -> ovfl=1. 8 or 9 frames are transmitted in order starting 8'h01, depending on pops during the burst. The number of frames sent plus the number of drops equals 10, and no byte is reordered.
- Flush mid-frame: push 8'h67, 8'h73, 8'h3F, then flush during the first frame's DATA state -> the 8'h67 frame completes, no further frames are sent, count=0, ovfl=0.
- Gap/stop bits, with GAP_CYC=20, STOP_BITS=2: push two bytes -> TX high for 2*BAUD_DIV+20+2 clocks between the last data bit and the next start bit.
- Reset mid-frame: assert rst_n low during bit 4 -> TX=1 in the same cycle. After release, with UART_CMD_SEQ_PARITY_EN defined and par_odd=0, push 8'h67 -> parity bit = 1.
